// File: rtl/life_board_loader.sv
// Row-streaming writer for a 16x16 toroidal life engine: assembles 16 row
// beats into a shadow board, commits it atomically with a one-cycle load
// strobe, flags framing errors and tracks generations since the last commit.
module life_board_loader (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_row,
  input  logic         in_last,
  output logic         load,
  output logic [255:0] data,
  output logic         frame_err,
  output logic [7:0]   frames_ok,
  output logic [15:0]  gen_count
);

  localparam int unsigned ROWS  = 16;
  localparam int unsigned COLS  = 16;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned FOK_W = 8;
  localparam int unsigned GEN_W = 16;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    COMMIT = 2'd1,
    DROP   = 2'd2
  } state_t;

  state_t                      state;
  state_t                      state_d;
  logic [IDX_W-1:0]            idx;
  logic [IDX_W-1:0]            idx_d;
  logic [ROWS-1:0][COLS-1:0]   shadow;
  logic                        accept;
  logic                        wr_en;
  logic                        commit;
  logic                        err_d;

  // Only the single commit cycle stalls the row stream.
  assign in_ready = (state != COMMIT);
  assign accept   = in_valid && in_ready;

  // Next-state, row index and commit/error decisions.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    wr_en   = 1'b0;
    commit  = 1'b0;
    err_d   = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          if (idx == LAST_IDX) begin
            idx_d = '0;
            if (in_last) begin
              commit  = 1'b1;
              state_d = COMMIT;
            end else begin
              err_d   = 1'b1;
              state_d = DROP;
            end
          end else if (in_last) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            wr_en = 1'b1;
            idx_d = idx + IDX_W'(1);
          end
        end
      end
      COMMIT: begin
        state_d = FILL;
        idx_d   = '0;
      end
      DROP: begin
        if (accept && in_last) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  // State and row index registers.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= FILL;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // Shadow board; the final row bypasses it straight into the commit.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      shadow <= '0;
    end else if (wr_en) begin
      shadow[idx] <= in_row;
    end
  end

  // Committed board, load strobe, error pulse and frame counter.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      data      <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
      frames_ok <= '0;
    end else begin
      load      <= commit;
      frame_err <= err_d;
      if (commit) begin
        data      <= {in_row, shadow[ROWS-2:0]};
        frames_ok <= frames_ok + FOK_W'(1);
      end
    end
  end

  // Generations since the engine sampled load; saturating.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      gen_count <= '0;
    end else if (load) begin
      gen_count <= '0;
    end else if (gen_count != {GEN_W{1'b1}}) begin
      gen_count <= gen_count + GEN_W'(1);
    end
  end

endmodule

// File: tb/tb_life_board_loader.sv
// Self-checking bench for life_board_loader: table of frame vectors plus
// hand-written reset, back-to-back, wrap and generation-counter sequences.
// Expected commits go to a scoreboard queue popped whenever load is seen.
module tb_life_board_loader;

  logic         clk = 1'b0;
  logic         areset_n;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_row;
  logic         in_last;
  logic         load;
  logic [255:0] data;
  logic         frame_err;
  logic [7:0]   frames_ok;
  logic [15:0]  gen_count;

  life_board_loader dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_last   (in_last),
    .load      (load),
    .data      (data),
    .frame_err (frame_err),
    .frames_ok (frames_ok),
    .gen_count (gen_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic [7:0]   fok;
  } exp_t;

  typedef struct {
    string            name;
    logic [19:0][15:0] rows;
    int               nbeats;
    int               last_at;
    bit               commit;
    int               errs;
  } vec_t;

  exp_t         sbq[$];
  vec_t         vecs[7];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           load_cnt = 0;
  int           err_cnt = 0;
  int           last_load_cyc = 0;
  int           prev_load_cyc = 0;
  logic [7:0]   model_fok = 8'd0;
  logic [255:0] model_data = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every load cycle must match the oldest expected commit.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (areset_n) begin
      if (frame_err) err_cnt++;
      if (load) begin
        load_cnt++;
        prev_load_cyc = last_load_cyc;
        last_load_cyc = cyc;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: load=1 expected 0");
        end else begin
          e = sbq.pop_front();
          chk("commit_data", data, e.data);
          chk("commit_frames_ok", 256'(frames_ok), 256'(e.fok));
          chk("commit_in_ready", 256'(in_ready), 256'(0));
        end
      end
    end
  end

  task automatic expect_commit(input logic [255:0] d);
    model_fok  = model_fok + 8'd1;
    model_data = d;
    sbq.push_back('{d, model_fok});
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat until accepted; returns 1 time unit after the accepting edge.
  task automatic beat(input logic [15:0] row, input logic last);
    bit ok;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_row   = row;
    in_last  = last;
    do begin
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_accept: in_ready=0 for 50 cycles expected 1");
    end
  endtask

  task automatic send_frame(input logic [19:0][15:0] rows, input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++) beat(rows[i], (i + 1) == last_at);
  endtask

  task automatic random_rows(output logic [19:0][15:0] rows);
    for (int i = 0; i < 20; i++) rows[i] = 16'($urandom);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_load"}, 256'(load), 256'(0));
    chk({tag, "_data"}, data, 256'(0));
    chk({tag, "_frames_ok"}, 256'(frames_ok), 256'(0));
    chk({tag, "_gen_count"}, 256'(gen_count), 256'(0));
    chk({tag, "_in_ready"}, 256'(in_ready), 256'(1));
    chk({tag, "_frame_err"}, 256'(frame_err), 256'(0));
  endtask

  task automatic release_reset();
    #20;
    @(negedge clk);
    areset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!load && n < 40);
    if (!load) begin
      checks++;
      errors++;
      $display("FAIL %s: load=0 after 40 cycles expected 1", tag);
    end
  endtask

  initial begin
    logic [19:0][15:0] r1;
    logic [19:0][15:0] r2;
    logic [255:0]      d;
    int                l0;
    int                e0;

    areset_n = 1'b0;
    in_valid = 1'b0;
    in_row   = '0;
    in_last  = 1'b0;

    // Frame vectors: inputs and expected outcomes.
    for (int v = 0; v < 7; v++) begin
      random_rows(vecs[v].rows);
      vecs[v].nbeats  = 16;
      vecs[v].last_at = 16;
      vecs[v].commit  = 1'b1;
      vecs[v].errs    = 0;
    end
    vecs[0].name = "glider";
    vecs[0].rows = '0;
    vecs[0].rows[1] = 16'h0002;
    vecs[0].rows[2] = 16'h0004;
    vecs[0].rows[3] = 16'h0007;
    vecs[1].name = "short5";
    vecs[1].nbeats = 5;  vecs[1].last_at = 5;  vecs[1].commit = 1'b0; vecs[1].errs = 1;
    vecs[2].name = "after_short";
    vecs[3].name = "long20";
    vecs[3].nbeats = 20; vecs[3].last_at = 20; vecs[3].commit = 1'b0; vecs[3].errs = 1;
    vecs[4].name = "after_long";
    for (int i = 0; i < 16; i++) vecs[4].rows[i] = 16'(i * 16'h1111);
    vecs[5].name = "short1";
    vecs[5].nbeats = 1;  vecs[5].last_at = 1;  vecs[5].commit = 1'b0; vecs[5].errs = 1;
    vecs[6].name = "all_ones";
    vecs[6].rows = '1;

    #12;
    check_reset_values("por");
    release_reset();

    for (int v = 0; v < 7; v++) begin
      l0 = load_cnt;
      e0 = err_cnt;
      if (vecs[v].commit) begin
        d = vecs[v].rows[15:0];
        expect_commit(d);
      end
      send_frame(vecs[v].rows, vecs[v].nbeats, vecs[v].last_at);
      idle(4);
      chk({vecs[v].name, "_loads"}, 256'(load_cnt - l0), 256'(vecs[v].commit ? 1 : 0));
      chk({vecs[v].name, "_errs"}, 256'(err_cnt - e0), 256'(vecs[v].errs));
      chk({vecs[v].name, "_data_hold"}, data, model_data);
      chk({vecs[v].name, "_frames_ok"}, 256'(frames_ok), 256'(model_fok));
    end

    // frame_err lands exactly in the cycle after the offending beat.
    beat(16'h1234, 1'b0);
    beat(16'h5678, 1'b0);
    beat(16'h9abc, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("err_timing_high", 256'(frame_err), 256'(1));
    @(negedge clk);
    chk("err_timing_low", 256'(frame_err), 256'(0));
    @(posedge clk);
    #1;

    // Back-to-back frames with in_valid held high through COMMIT.
    random_rows(r1);
    random_rows(r2);
    d = r1[15:0];
    expect_commit(d);
    d = r2[15:0];
    expect_commit(d);
    l0 = load_cnt;
    send_frame(r1, 16, 16);
    send_frame(r2, 16, 16);
    idle(4);
    chk("b2b_loads", 256'(load_cnt - l0), 256'(2));
    chk("b2b_gap", 256'(last_load_cyc - prev_load_cyc), 256'(17));
    chk("b2b_data", data, model_data);

    // Reset mid-frame aborts it; a following frame commits normally.
    random_rows(r1);
    send_frame(r1, 7, 16);
    #2;
    areset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_values("mid_rst");
    model_fok  = 8'd0;
    model_data = '0;
    sbq.delete();
    release_reset();
    random_rows(r1);
    d = r1[15:0];
    expect_commit(d);
    l0 = load_cnt;
    send_frame(r1, 16, 16);
    idle(4);
    chk("mid_rst_recommit", 256'(load_cnt - l0), 256'(1));

    // Reset during the COMMIT cycle: no load survives, counter stays 0.
    random_rows(r1);
    l0 = load_cnt;
    send_frame(r1, 16, 16);
    areset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_values("commit_rst");
    model_fok  = 8'd0;
    model_data = '0;
    release_reset();
    idle(3);
    chk("commit_rst_noload", 256'(load_cnt - l0), 256'(0));

    // 260 back-to-back commits walk frames_ok through its 255->0 wrap.
    for (int f = 0; f < 260; f++) begin
      random_rows(r1);
      d = r1[15:0];
      expect_commit(d);
      send_frame(r1, 16, 16);
    end
    idle(4);
    chk("wrap_frames_ok", 256'(frames_ok), 256'(8'd4));

    // Generation counter: 5 after five edges, saturates, cleared by commit.
    random_rows(r1);
    d = r1[15:0];
    expect_commit(d);
    send_frame(r1, 16, 16);
    in_valid = 1'b0;
    wait_load("gen_load1");
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("gen_five", 256'(gen_count), 256'(5));
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("gen_saturate", 256'(gen_count), 256'(16'hFFFF));
    @(posedge clk);
    #1;
    random_rows(r1);
    d = r1[15:0];
    expect_commit(d);
    send_frame(r1, 16, 16);
    in_valid = 1'b0;
    wait_load("gen_load2");
    @(posedge clk);
    @(negedge clk);
    chk("gen_cleared", 256'(gen_count), 256'(0));
    @(posedge clk);
    @(negedge clk);
    chk("gen_restart", 256'(gen_count), 256'(1));

    chk("scoreboard_empty", 256'(sbq.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
